// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control path: opcodes, ALU operations,
// immediate/result selects and the per-stage control bundles.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        jalr;
        alu_op_e     alu_ctrl;
        logic        alu_src;
        logic [2:0]  funct3;
    } ctrl_e_t;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic [2:0]  funct3;
    } ctrl_m_t;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
    } ctrl_w_t;

    // Condition selected by the branch funct3; the base ISA only knows beq.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zero,
                                          input logic       lt,
                                          input logic       ltu,
                                          input bit         ext);
        logic taken;
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ext & ~zero;
            3'b100:  taken = ext & lt;
            3'b101:  taken = ext & ~lt;
            3'b110:  taken = ext & ltu;
            3'b111:  taken = ext & ~ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pipe_controller_decode.sv
// Combinational main and ALU decode for the Decode stage. Anything not
// decodable under the selected ISA subset comes out as an all-zero bubble.
module pipe_decode
    import pipe_ctrl_pkg::*;
#(
    parameter bit EXT_ISA = 1'b1
) (
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output ctrl_e_t    ctrl_o,
    output imm_src_e   imm_src_o,
    output logic       illegal_o
);

    logic    is_rtype;
    logic    alu_funct_ok;
    logic    branch_ok;
    alu_op_e alu_fn;

    assign is_rtype = (op_i == OP_RTYPE);

    // Base ISA keeps only add/sub, slt, or, and.
    always_comb begin
        alu_funct_ok = 1'b1;
        if (!EXT_ISA) begin
            alu_funct_ok = (funct3_i == 3'b000) || (funct3_i == 3'b010) ||
                           (funct3_i == 3'b110) || (funct3_i == 3'b111);
        end
    end

    assign branch_ok = EXT_ISA ? (funct3_i[2:1] != 2'b01) : (funct3_i == 3'b000);

    always_comb begin
        alu_fn = ALU_ADD;
        case (funct3_i)
            3'b000:  alu_fn = (is_rtype && funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_fn = ALU_SLL;
            3'b010:  alu_fn = ALU_SLT;
            3'b011:  alu_fn = ALU_SLTU;
            3'b100:  alu_fn = ALU_XOR;
            3'b101:  alu_fn = funct7b5_i ? ALU_SRA : ALU_SRL;
            3'b110:  alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase
    end

    always_comb begin
        ctrl_o    = '0;
        imm_src_o = IMM_I;
        illegal_o = 1'b0;
        case (op_i)
            OP_LOAD: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.result_src = RES_MEM;
            end
            OP_STORE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                imm_src_o        = IMM_S;
            end
            OP_RTYPE, OP_ITYPE: begin
                if (alu_funct_ok) begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_src   = ~is_rtype;
                    ctrl_o.alu_ctrl  = alu_fn;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (branch_ok) begin
                    ctrl_o.branch   = 1'b1;
                    ctrl_o.alu_ctrl = ALU_SUB;
                    imm_src_o       = IMM_B;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OP_JAL: begin
                ctrl_o.jump       = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.result_src = RES_PC4;
                imm_src_o         = IMM_J;
            end
            OP_JALR: begin
                if (EXT_ISA) begin
                    ctrl_o.jump       = 1'b1;
                    ctrl_o.jalr       = 1'b1;
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.alu_src    = 1'b1;
                    ctrl_o.result_src = RES_PC4;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OP_LUI: begin
                if (EXT_ISA) begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.result_src = RES_IMM;
                    imm_src_o         = IMM_U;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
        if (!illegal_o) begin
            ctrl_o.funct3 = funct3_i;
        end
    end

endmodule

// File: rtl/pipe_controller.sv
// Five-stage control path: decode, then E/M/W control registers with stall and
// flush on E, plus branch/jump resolution in Execute.
module pipe_controller
    import pipe_ctrl_pkg::*;
#(
    parameter bit EXT_ISA   = 1'b1,
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opD,
    input  logic [2:0]           funct3D,
    input  logic                 funct7b5D,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 ZeroE,
    input  logic                 LtE,
    input  logic                 LtuE,
    output logic [2:0]           ImmSrcD,
    output logic                 IllegalD,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 ResultSrcE0,
    output logic                 RegWriteE,
    output logic                 PCSrcE,
    output logic                 JalrE,
    output logic                 MemWriteM,
    output logic                 RegWriteM,
    output logic [2:0]           Funct3M,
    output logic [1:0]           ResultSrcW,
    output logic                 RegWriteW
);

    if ((EXT_ISA && ALUCTRL_W < 4) || ALUCTRL_W < 3) begin : g_bad_width
        $error("pipe_controller: ALUCTRL_W too narrow for the selected ISA");
    end

    ctrl_e_t  ctrl_dec;
    imm_src_e imm_src_dec;

    ctrl_e_t  e_d, e_q;
    ctrl_m_t  m_d, m_q;
    ctrl_w_t  w_d, w_q;

    pipe_decode #(
        .EXT_ISA(EXT_ISA)
    ) u_decode (
        .op_i      (opD),
        .funct3_i  (funct3D),
        .funct7b5_i(funct7b5D),
        .ctrl_o    (ctrl_dec),
        .imm_src_o (imm_src_dec),
        .illegal_o (IllegalD)
    );

    assign ImmSrcD = imm_src_dec;

    // A held E stage must not also flow into M, so M takes a bubble instead.
    always_comb begin
        e_d = e_q;
        if (FlushE) begin
            e_d = '0;
        end else if (!StallE) begin
            e_d = ctrl_dec;
        end

        m_d = '0;
        if (!(StallE && !FlushE)) begin
            m_d.reg_write  = e_q.reg_write;
            m_d.result_src = e_q.result_src;
            m_d.mem_write  = e_q.mem_write;
            m_d.funct3     = e_q.funct3;
        end

        w_d.reg_write  = m_q.reg_write;
        w_d.result_src = m_q.result_src;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign ALUControlE = ALUCTRL_W'(e_q.alu_ctrl);
    assign ALUSrcE     = e_q.alu_src;
    assign ResultSrcE0 = e_q.result_src[0];
    assign RegWriteE   = e_q.reg_write;
    assign JalrE       = e_q.jalr;
    assign PCSrcE      = e_q.jump |
                         (e_q.branch & branch_taken(e_q.funct3, ZeroE, LtE, LtuE, EXT_ISA));

    assign MemWriteM   = m_q.mem_write;
    assign RegWriteM   = m_q.reg_write;
    assign Funct3M     = m_q.funct3;

    assign ResultSrcW  = w_q.result_src;
    assign RegWriteW   = w_q.reg_write;

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller: an extended-ISA and a base-ISA instance
// share stimulus and are checked against an instruction-level pipeline model.
module tb_pipe_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opD;
    logic [2:0] funct3D;
    logic       funct7b5D, StallE, FlushE, ZeroE, LtE, LtuE;

    logic [2:0] x_ImmSrcD, b_ImmSrcD;
    logic       x_IllegalD, b_IllegalD;
    logic [3:0] x_ALUControlE;
    logic [2:0] b_ALUControlE;
    logic       x_ALUSrcE, x_ResultSrcE0, x_RegWriteE, x_PCSrcE, x_JalrE;
    logic       b_ALUSrcE, b_ResultSrcE0, b_RegWriteE, b_PCSrcE, b_JalrE;
    logic       x_MemWriteM, x_RegWriteM, b_MemWriteM, b_RegWriteM;
    logic [2:0] x_Funct3M, b_Funct3M;
    logic [1:0] x_ResultSrcW, b_ResultSrcW;
    logic       x_RegWriteW, b_RegWriteW;

    always #5 clk = ~clk;

    pipe_controller #(.EXT_ISA(1'b1), .ALUCTRL_W(4)) u_ext (
        .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
        .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .ImmSrcD(x_ImmSrcD), .IllegalD(x_IllegalD), .ALUControlE(x_ALUControlE),
        .ALUSrcE(x_ALUSrcE), .ResultSrcE0(x_ResultSrcE0), .RegWriteE(x_RegWriteE),
        .PCSrcE(x_PCSrcE), .JalrE(x_JalrE), .MemWriteM(x_MemWriteM), .RegWriteM(x_RegWriteM),
        .Funct3M(x_Funct3M), .ResultSrcW(x_ResultSrcW), .RegWriteW(x_RegWriteW)
    );

    pipe_controller #(.EXT_ISA(1'b0), .ALUCTRL_W(3)) u_base (
        .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
        .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .ImmSrcD(b_ImmSrcD), .IllegalD(b_IllegalD), .ALUControlE(b_ALUControlE),
        .ALUSrcE(b_ALUSrcE), .ResultSrcE0(b_ResultSrcE0), .RegWriteE(b_RegWriteE),
        .PCSrcE(b_PCSrcE), .JalrE(b_JalrE), .MemWriteM(b_MemWriteM), .RegWriteM(b_RegWriteM),
        .Funct3M(b_Funct3M), .ResultSrcW(b_ResultSrcW), .RegWriteW(b_RegWriteW)
    );

    localparam bit [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
    localparam bit [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111;
    localparam bit [6:0] IDLE = 7'b0000000;

    typedef struct {
        bit       rw;
        bit [1:0] rs;
        bit       mw;
        bit       jump;
        bit       br;
        bit       jalr;
        int       alu;
        bit       alusrc;
        bit [2:0] f3;
    } ctl_t;

    typedef struct {
        ctl_t     c;
        bit       ill;
        bit [2:0] imm;
    } dec_t;

    typedef struct {
        int k;
        int ill, imm, alu, alusrc, rs0, rwE, pcsrc, jalr, mwM, rwM, f3M, rsW, rwW;
    } exp_t;

    exp_t sbq[$];
    ctl_t me_s[2], mm_s[2], mw_s[2];
    bit [6:0] p_op;
    bit [2:0] p_f3;
    bit       p_f7, p_stall, p_flush;
    int       n_tests = 0;
    int       n_fail  = 0;
    int       cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ctl_t bubble();
        ctl_t c = '{default: 0};
        return c;
    endfunction

    // Instruction-level view of the ISA rules; ext selects the full subset.
    function automatic dec_t decode_spec(bit [6:0] op, bit [2:0] f3, bit f7, bit ext);
        dec_t d;
        bit   ok;
        d.c = bubble();
        d.ill = 1'b0;
        d.imm = 3'd0;
        case (op)
            LW: begin d.c.rw = 1; d.c.alusrc = 1; d.c.rs = 2'b01; end
            SW: begin d.c.mw = 1; d.c.alusrc = 1; d.imm = 3'd1; end
            RT, IT: begin
                ok = ext || f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7;
                if (!ok) d.ill = 1;
                else begin
                    d.c.rw = 1;
                    d.c.alusrc = (op == IT);
                    case (f3)
                        3'd0: d.c.alu = (op == RT && f7) ? 1 : 0;
                        3'd1: d.c.alu = 7;
                        3'd2: d.c.alu = 5;
                        3'd3: d.c.alu = 6;
                        3'd4: d.c.alu = 4;
                        3'd5: d.c.alu = f7 ? 9 : 8;
                        3'd6: d.c.alu = 3;
                        default: d.c.alu = 2;
                    endcase
                end
            end
            BR: begin
                ok = ext ? (f3 != 3'd2 && f3 != 3'd3) : (f3 == 3'd0);
                if (!ok) d.ill = 1;
                else begin d.c.br = 1; d.c.alu = 1; d.imm = 3'd2; end
            end
            JAL: begin d.c.jump = 1; d.c.rw = 1; d.c.rs = 2'b10; d.imm = 3'd3; end
            JALR: begin
                if (!ext) d.ill = 1;
                else begin
                    d.c.jump = 1; d.c.jalr = 1; d.c.rw = 1; d.c.alusrc = 1; d.c.rs = 2'b10;
                end
            end
            LUI: begin
                if (!ext) d.ill = 1;
                else begin d.c.rw = 1; d.c.rs = 2'b11; d.imm = 3'd4; end
            end
            default: d.ill = 1;
        endcase
        if (!d.ill) d.c.f3 = f3;
        return d;
    endfunction

    // Branch outcome from the operand relation itself, not from the flags.
    function automatic bit taken_spec(bit [2:0] f3, bit [31:0] a, bit [31:0] b, bit ext);
        case (f3)
            3'd0: return a == b;
            3'd1: return ext && a != b;
            3'd4: return ext && $signed(a) < $signed(b);
            3'd5: return ext && !($signed(a) < $signed(b));
            3'd6: return ext && a < b;
            3'd7: return ext && !(a < b);
            default: return 0;
        endcase
    endfunction

    task automatic model_advance();
        for (int k = 0; k < 2; k++) begin
            dec_t d;
            d = decode_spec(p_op, p_f3, p_f7, k == 1);
            mw_s[k] = mm_s[k];
            mm_s[k] = (p_stall && !p_flush) ? bubble() : me_s[k];
            if (p_flush)       me_s[k] = bubble();
            else if (!p_stall) me_s[k] = d.c;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            me_s[k] = bubble(); mm_s[k] = bubble(); mw_s[k] = bubble();
        end
    endtask

    task automatic chk(string inst, string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s cycle %0d: got %0d, expected %0d", inst, name, cyc, act, exp);
        end
    endtask

    task automatic drive(bit [6:0] op, bit [2:0] f3, bit f7, bit stall, bit flush,
                         bit [31:0] a, bit [31:0] b);
        opD = op; funct3D = f3; funct7b5D = f7; StallE = stall; FlushE = flush;
        ZeroE = (a == b); LtE = ($signed(a) < $signed(b)); LtuE = (a < b);
        p_op = op; p_f3 = f3; p_f7 = f7; p_stall = stall; p_flush = flush;
    endtask

    task automatic step(bit [6:0] op, bit [2:0] f3, bit f7, bit stall, bit flush,
                        bit [31:0] a, bit [31:0] b);
        @(posedge clk);
        model_advance();
        #1;
        drive(op, f3, f7, stall, flush, a, b);
        for (int k = 1; k >= 0; k--) begin
            exp_t e;
            dec_t d;
            d = decode_spec(op, f3, f7, k == 1);
            e.k = k;
            e.ill = d.ill; e.imm = d.imm;
            e.alu = me_s[k].alu; e.alusrc = me_s[k].alusrc; e.rs0 = me_s[k].rs[0];
            e.rwE = me_s[k].rw; e.jalr = me_s[k].jalr;
            e.pcsrc = me_s[k].jump || (me_s[k].br && taken_spec(me_s[k].f3, a, b, k == 1));
            e.mwM = mm_s[k].mw; e.rwM = mm_s[k].rw; e.f3M = mm_s[k].f3;
            e.rsW = mw_s[k].rs; e.rwW = mw_s[k].rw;
            sbq.push_back(e);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(IDLE, 3'd0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
    endtask

    initial begin : monitor
        exp_t e;
        string t;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.k == 1) begin
                    t = "ext";
                    chk(t, "IllegalD", int'(x_IllegalD), e.ill);
                    chk(t, "ImmSrcD", int'(x_ImmSrcD), e.imm);
                    chk(t, "ALUControlE", int'(x_ALUControlE), e.alu);
                    chk(t, "ALUSrcE", int'(x_ALUSrcE), e.alusrc);
                    chk(t, "ResultSrcE0", int'(x_ResultSrcE0), e.rs0);
                    chk(t, "RegWriteE", int'(x_RegWriteE), e.rwE);
                    chk(t, "PCSrcE", int'(x_PCSrcE), e.pcsrc);
                    chk(t, "JalrE", int'(x_JalrE), e.jalr);
                    chk(t, "MemWriteM", int'(x_MemWriteM), e.mwM);
                    chk(t, "RegWriteM", int'(x_RegWriteM), e.rwM);
                    chk(t, "Funct3M", int'(x_Funct3M), e.f3M);
                    chk(t, "ResultSrcW", int'(x_ResultSrcW), e.rsW);
                    chk(t, "RegWriteW", int'(x_RegWriteW), e.rwW);
                end else begin
                    t = "base";
                    chk(t, "IllegalD", int'(b_IllegalD), e.ill);
                    chk(t, "ImmSrcD", int'(b_ImmSrcD), e.imm);
                    chk(t, "ALUControlE", int'(b_ALUControlE), e.alu);
                    chk(t, "ALUSrcE", int'(b_ALUSrcE), e.alusrc);
                    chk(t, "ResultSrcE0", int'(b_ResultSrcE0), e.rs0);
                    chk(t, "RegWriteE", int'(b_RegWriteE), e.rwE);
                    chk(t, "PCSrcE", int'(b_PCSrcE), e.pcsrc);
                    chk(t, "JalrE", int'(b_JalrE), e.jalr);
                    chk(t, "MemWriteM", int'(b_MemWriteM), e.mwM);
                    chk(t, "RegWriteM", int'(b_RegWriteM), e.rwM);
                    chk(t, "Funct3M", int'(b_Funct3M), e.f3M);
                    chk(t, "ResultSrcW", int'(b_ResultSrcW), e.rsW);
                    chk(t, "RegWriteW", int'(b_RegWriteW), e.rwW);
                end
            end
        end
    end

    task automatic check_all_zero(string tag);
        chk(tag, "ext.RegWriteE", int'(x_RegWriteE), 0);
        chk(tag, "ext.PCSrcE", int'(x_PCSrcE), 0);
        chk(tag, "ext.ALUControlE", int'(x_ALUControlE), 0);
        chk(tag, "ext.MemWriteM", int'(x_MemWriteM), 0);
        chk(tag, "ext.RegWriteM", int'(x_RegWriteM), 0);
        chk(tag, "ext.ResultSrcW", int'(x_ResultSrcW), 0);
        chk(tag, "ext.RegWriteW", int'(x_RegWriteW), 0);
        chk(tag, "base.MemWriteM", int'(b_MemWriteM), 0);
        chk(tag, "base.RegWriteW", int'(b_RegWriteW), 0);
    endtask

    // Reset raised between edges while the sw issued two steps earlier sits in M.
    task automatic reset_mid_stream();
        @(posedge clk);
        model_advance();
        #1;
        drive(IDLE, 3'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2);
        #1;
        chk("mid", "MemWriteM_before_reset", int'(x_MemWriteM), int'(mm_s[1].mw));
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    bit [6:0] op_tab[8] = '{LW, SW, RT, IT, BR, JAL, JALR, LUI};

    initial begin : stimulus
        bit [6:0]  op;
        bit [31:0] a, b;
        reset = 1'b1;
        drive(IDLE, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1);
        model_clear();
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        step(LW, 3'b010, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1);
        idle(4);
        step(BR, 3'b001, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1);
        step(IDLE, 3'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2);
        step(BR, 3'b110, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1);
        step(IDLE, 3'd0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd3);
        step(BR, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1);
        step(IDLE, 3'd0, 1'b0, 1'b0, 1'b0, 32'd7, 32'd7);
        step(RT, 3'b101, 1'b1, 1'b0, 1'b0, 32'd0, 32'd1);
        step(RT, 3'b000, 1'b1, 1'b0, 1'b0, 32'd0, 32'd1);
        step(IT, 3'b000, 1'b1, 1'b0, 1'b0, 32'd0, 32'd1);
        idle(2);
        step(LW, 3'b010, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1);
        step(IDLE, 3'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd1);
        step(IDLE, 3'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd1);
        idle(4);
        step(JAL, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1);
        step(JAL, 3'd0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd1);
        idle(4);
        step(JALR, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1);
        step(LUI, 3'd3, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1);
        idle(3);
        step(SW, 3'b010, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1);
        idle(1);
        reset_mid_stream();
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            int sel = $urandom_range(0, 9);
            op = (sel < 8) ? op_tab[sel] : 7'($urandom);
            a = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            else if ($urandom_range(0, 1) == 0) b = a ^ 32'h8000_0000;
            else b = $urandom;
            step(op, 3'($urandom), 1'($urandom),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, a, b);
        end
        idle(4);

        repeat (3) @(negedge clk);
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_controller.md
# pipe_controller

Parametrised five-stage control path for the RISC-V pipeline. Decodes the instruction in Decode, then carries control fields through the Execute, Memory and Writeback pipeline registers, with stall and flush support. Resolves the full branch/jump decision in Execute, covering all six conditional branches and jalr. Sits beside the datapath. The hazard unit drives its stall and flush inputs.

## Interface
Parameters:
- EXT_ISA, default 1: 1 enables xor/sll/srl/sra/sltu, bne/blt/bge/bltu/bgeu, jalr and lui. 0 limits decode to lw/sw/R/I add/sub/and/or/slt, beq and jal.
- ALUCTRL_W, default 4: width of the ALU control field. Must be ≥4 when EXT_ISA=1 and ≥3 otherwise.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all stage registers
- opD  in  7  opcode
- funct3D  in  3  funct3
- funct7b5D  in  1  instr[30]
- StallE  in  1  hold the E register
- FlushE  in  1  load a bubble into the E register
- ZeroE, LtE, LtuE  in  1 each  ALU flags: equal, signed less-than, unsigned less-than
- ImmSrcD  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- IllegalD  out  1  opcode or funct is not decodable under EXT_ISA
- ALUControlE  out  ALUCTRL_W  ALU operation code
- ALUSrcE  out  1  1 = immediate operand
- ResultSrcE0  out  1  ResultSrcE[0], used for load-use detection
- RegWriteE  out  1  register write in E
- PCSrcE  out  1  redirect the PC
- JalrE  out  1  1 = target is the ALU result, 0 = PC+imm
- MemWriteM  out  1  store in M
- RegWriteM  out  1  register write in M
- Funct3M  out  3  load/store width
- ResultSrcW  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm
- RegWriteW  out  1  register write in W

## Operation
- Decode stage, combinational:
  - lw: RegWrite, ALUSrc, ResultSrc=01, I-type immediate.
  - sw: MemWrite, ALUSrc, S-type immediate.
  - R-type: RegWrite.
  - I-ALU: RegWrite, ALUSrc.
  - branch: Branch, B-type immediate, ALU op sub.
  - jal: Jump, RegWrite, ResultSrc=10, J-type immediate.
  - jalr: Jump, Jalr, RegWrite, ALUSrc, ResultSrc=10, I-type immediate, ALU op add.
  - lui: RegWrite, ResultSrc=11, U-type immediate.
- ALU op codes: add 0, sub 1, and 2, or 3, xor 4, slt 5, sltu 6, sll 7, srl 8, sra 9.
- sub is selected only for R-type with funct7b5=1. sra is selected for funct3=101 with funct7b5=1.
- Illegal instruction handling:
  - IllegalD=1.
  - All write and redirect controls forced to 0 (bubble).
  - ImmSrcD=000.
- E register fields: RegWrite, ResultSrc, MemWrite, Jump, Branch, Jalr, ALUControl, ALUSrc, funct3.
- M register fields: RegWrite, ResultSrc, MemWrite, funct3.
- W register fields: RegWrite, ResultSrc.
- PCSrcE = JumpE | (BranchE & taken). taken is selected by funct3E:
  - 000: ZeroE
  - 001: !ZeroE
  - 100: LtE
  - 101: !LtE
  - 110: LtuE
  - 111: !LtuE
  - others: 0
- With EXT_ISA=0, only 000 produces a taken branch.

## Timing
- Reset: every stage register clears to 0 immediately, without waiting for a clock edge. All E/M/W outputs read 0, including PCSrcE.
- Reset mid-stream: in-flight instructions are discarded and no writes escape.
- Latency: one cycle per stage. A decode in cycle n appears in E at n+1, M at n+2, W at n+3.
- FlushE=1: the E register loads all zeros on the next edge.
- StallE=1: the E register holds. The M register captures a bubble, so an instruction stalled in E is not duplicated into M.
- FlushE=1 and StallE=1 in the same cycle: flush wins.
- The M and W registers always advance.
- PCSrcE is combinational from the E register and the flags, valid in the same cycle.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - opcode constants
  - ALU op encodings
  - ImmSrc and ResultSrc encodings
  - packed struct ctrl_e_t for the E register fields
- One sub-module, pipe_decode, holds the combinational main and ALU decode parametrised by EXT_ISA. Stage registers and branch resolution live in the top module.

## Test plan
- lw (opD=0000011) then an idle stream: RegWriteW=1 and ResultSrcW=01 three cycles later. ResultSrcE0=1 one cycle after decode.
- bne with ZeroE=0: PCSrcE=1. bltu with LtuE=0: PCSrcE=0. With EXT_ISA=0, bne gives IllegalD=1 and PCSrcE=0.
- R-type funct3=101, funct7b5=1: ALUControlE=9 (sra). R-type funct3=000, funct7b5=1: ALUControlE=1 (sub).
- Load in E with StallE=1 for two cycles: the E fields hold. The M register sees a bubble for two cycles, then the load once.
- jal in D with FlushE and StallE both asserted: E all zero next cycle, PCSrcE=0.
- Assert reset asynchronously between edges while a sw is in M: MemWriteM drops to 0 immediately.
